// File: rtl/bcd_7seg_scanner.sv
// Four-digit multiplexed seven-segment driver for packed BCD input.
// Common-anode, active-low digit enables, segments and decimal point.
module bcd_7seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned NIB_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  localparam logic [3:0] AN_OFF   = 4'b1111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [15:0]      bcd_q;
  logic [3:0]       dp_q;
  logic [CNT_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;

  logic             tick;
  logic [IDX_W-1:0] idx_next;
  logic [NIB_W-1:0] nib;
  logic             upper_zero;
  logic             blank;
  logic [6:0]       glyph;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  // Holding registers for the displayed word and decimal points
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q <= 16'h0000;
      dp_q  <= 4'h0;
    end else if (load) begin
      bcd_q <= bcd_in;
      dp_q  <= dp_in;
    end
  end

  // Refresh divider and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= idx_next;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // Registered display outputs, refreshed only on tick edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (tick) begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

  // Select the upcoming digit's nibble and decide whether it is a leading zero
  always_comb begin
    tick       = (div_cnt == CNT_MAX);
    idx_next   = idx + IDX_W'(1);
    nib        = bcd_q[3:0];
    upper_zero = 1'b0;
    case (idx_next)
      2'd0: begin
        nib        = bcd_q[3:0];
        upper_zero = 1'b0;
      end
      2'd1: begin
        nib        = bcd_q[7:4];
        upper_zero = (bcd_q[15:4] == 12'h000);
      end
      2'd2: begin
        nib        = bcd_q[11:8];
        upper_zero = (bcd_q[15:8] == 8'h00);
      end
      default: begin
        nib        = bcd_q[15:12];
        upper_zero = (bcd_q[15:12] == 4'h0);
      end
    endcase
    blank = blank_lz & upper_zero;
  end

  // BCD to active-low {g..a}; non-decimal nibbles render as a dash
  always_comb begin
    glyph = SEG_DASH;
    case (nib)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = SEG_DASH;
    endcase
  end

  // Next slot drive; a blanked slot turns everything off including dp
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (!blank) begin
      an_nxt  = ~(4'b0001 << idx_next);
      seg_nxt = glyph;
      dp_nxt  = ~dp_q[idx_next];
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// Randomized scoreboard bench for bcd_7seg_scanner with a slot-level reference model.
module tb_bcd_7seg_scanner;

  localparam int unsigned R = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_7seg_scanner #(.REFRESH_DIV(R)) dut (
    .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16];
  initial begin
    glyph_tab[0] = 7'b1000000; glyph_tab[1] = 7'b1111001; glyph_tab[2] = 7'b0100100;
    glyph_tab[3] = 7'b0110000; glyph_tab[4] = 7'b0011001; glyph_tab[5] = 7'b0010010;
    glyph_tab[6] = 7'b0000010; glyph_tab[7] = 7'b1111000; glyph_tab[8] = 7'b0000000;
    glyph_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) glyph_tab[i] = 7'b0111111;
  end

  // Expected {an,seg,dp} for displaying digit d of a held word
  function automatic logic [11:0] slot_expect(int d, logic [15:0] b, logic [3:0] p, logic blz);
    int v;
    int n;
    logic [3:0] a;
    v = int'(b);
    if (blz && d > 0 && (v >> (4 * d)) == 0) return 12'hFFF;
    n = (v >> (4 * d)) % 16;
    a = 4'hF ^ 4'(1 << d);
    return {a, glyph_tab[n], ~p[d]};
  endfunction

  task automatic chk(string nm, logic [11:0] act, logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
               nm, $time, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // Reference model: slot k starts on the k-th multiple of R edges after reset
  int          cyc = 0;
  logic [15:0] m_bcd = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic [11:0] exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0;
      m_bcd = 16'h0;
      m_dp = 4'h0;
      exp_q.delete();
      exp_q.push_back(12'hFFF);
    end else begin
      cyc++;
      if (cyc % R == 0)
        exp_q.push_back(slot_expect((cyc / R) % 4, m_bcd, m_dp, blank_lz));
      if (load) begin
        m_bcd = bcd_in;
        m_dp = dp_in;
      end
    end
  end

  // Monitor: every cycle the outputs must equal the most recent slot expectation
  logic [11:0] cur = 12'hFFF;
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    chk("slot", {an, seg, dp}, cur);
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(logic [15:0] b, logic [3:0] p);
    load = 1'b1;
    bcd_in = b;
    dp_in = p;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int guard;
    reset = 1'b1; load = 1'b0; bcd_in = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
    step(3);
    chk("reset_state", {an, seg, dp}, 12'hFFF);
    reset = 1'b0;

    do_load(16'h1234, 4'h0);
    step(8 * R);

    blank_lz = 1'b1;
    do_load(16'h0007, 4'h0);
    step(8 * R);
    blank_lz = 1'b0;
    step(8 * R);

    blank_lz = 1'b1;
    do_load(16'h0000, 4'h0);
    step(8 * R);
    do_load(16'h0A05, 4'h0);
    step(8 * R);

    blank_lz = 1'b0;
    do_load(16'h5678, 4'b0100);
    step(8 * R);

    // Load landing exactly on a tick edge
    while (cyc % R != R - 1) @(negedge clk);
    do_load(16'h4321, 4'hF);
    step(8 * R);

    // Asynchronous reset while digit 2 is on
    guard = 0;
    while (an !== 4'b1011 && guard < 10 * R) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_digit2", {an, 8'hFF}, {4'b1011, 8'hFF});
    #2 reset = 1'b1;
    #1 chk("async_reset", {an, seg, dp}, 12'hFFF);
    @(negedge clk);
    reset = 1'b0;
    step(8 * R);

    // Randomized loads, values and blanking
    repeat (400) begin
      if ($urandom % 8 == 0) begin
        case ($urandom % 3)
          0: bcd_in = 16'($urandom);
          1: bcd_in = 16'($urandom % 16) << (4 * ($urandom % 4));
          default: bcd_in = 16'(($urandom % 10) * 16'h0111) & 16'h0FFF;
        endcase
        dp_in = 4'($urandom);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom % 16 == 0) blank_lz = ~blank_lz;
      @(negedge clk);
    end
    load = 1'b0;

    step(8 * R);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
